// File: rtl/fetch_prefetch_queue_pkg.sv
// Shared types and constants for the instruction prefetch path.
//   fetch_len_t   : instruction length, 1 or 2 bytes
//   FETCH_LEN_BIT : bit of the first instruction byte that marks a 2-byte instruction
//   fetch_state_t : fetch FSM state (first response after reset/redirect, or streaming)
package fetch_prefetch_queue_pkg;

    typedef enum logic {
        LEN1 = 1'b0,
        LEN2 = 1'b1
    } fetch_len_t;

    localparam int unsigned FETCH_LEN_BIT = 1;

    typedef enum logic {
        FS_FIRST  = 1'b0,
        FS_STREAM = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_prefetch_queue_byte_queue.sv
// fetch_byte_queue: circular byte buffer for the prefetch queue.
// Accepts one memory word per cycle, storing only the bytes at or above
// wr_off_i, and exposes a 2-byte peek at the head with a 1- or 2-byte pop.
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   flush_i               empty the queue (wins over write and pop)
//   wr_en_i, wr_off_i     write bytes [wr_off_i .. MEM_BYTES-1] of wr_data_i
//   wr_data_i             memory word, byte 0 in the LSBs
//   pop_i, pop_len_i      remove 1 or 2 bytes from the head
//   peek_o                {head+1 byte, head byte}
//   count_o               bytes currently held
module fetch_byte_queue
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int unsigned QUEUE_BYTES = 8,
    parameter int unsigned MEM_BYTES   = 2,
    localparam int unsigned PTR_W = $clog2(QUEUE_BYTES),
    localparam int unsigned CNT_W = $clog2(QUEUE_BYTES + 1),
    localparam int unsigned OFF_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic                   wr_en_i,
    input  logic [OFF_W-1:0]       wr_off_i,
    input  logic [8*MEM_BYTES-1:0] wr_data_i,
    input  logic                   pop_i,
    input  fetch_len_t             pop_len_i,
    output logic [15:0]            peek_o,
    output logic [CNT_W-1:0]       count_o
);

    logic [7:0]       mem_q [QUEUE_BYTES];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] wr_n, pop_n;
    logic [PTR_W-1:0] wr_idx [MEM_BYTES];
    logic [MEM_BYTES-1:0] wr_mask;

    always_comb begin
        wr_n = '0;
        if (wr_en_i) begin
            wr_n = CNT_W'(MEM_BYTES) - CNT_W'(wr_off_i);
        end
        pop_n = '0;
        if (pop_i) begin
            pop_n = (pop_len_i == LEN2) ? CNT_W'(2) : CNT_W'(1);
        end
        // Byte i of the word lands (i - wr_off_i) slots past the tail.
        for (int unsigned i = 0; i < MEM_BYTES; i++) begin
            wr_mask[i] = wr_en_i && !flush_i && (i >= 32'(wr_off_i));
            wr_idx[i]  = tail_q + PTR_W'(i - 32'(wr_off_i));
        end
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(pop_n);
            tail_d  = tail_q + PTR_W'(wr_n);
            count_d = count_q + wr_n - pop_n;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < MEM_BYTES; i++) begin
            if (wr_mask[i]) begin
                mem_q[wr_idx[i]] <= wr_data_i[8*i +: 8];
            end
        end
    end

    assign peek_o  = {mem_q[head_q + PTR_W'(1)], mem_q[head_q]};
    assign count_o = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue: streams instruction memory words into a byte queue and
// presents whole 1- or 2-byte instructions to decode via valid/ready.
// Optional feature macro: FETCH_BYPASS_EN -- when defined, a response arriving
// at an empty queue is presented to decode combinationally in the same cycle.
// Ports:
//   clk, rst_async_n            clock, asynchronous active-low reset
//   redirect_valid, redirect_pc load a new PC, flush the queue
//   inst_valid, inst_ready      decode handshake
//   inst, inst_len2, inst_pc    head instruction {byte1|0, byte0}, length, address
//   mem_req, mem_addr           synchronous memory read request (word address)
//   mem_rdata                   read data, one cycle after mem_req
module fetch_prefetch_queue
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int unsigned         PC_WIDTH    = 14,
    parameter int unsigned         MEM_BYTES   = 2,
    parameter int unsigned         QUEUE_BYTES = 8,
    parameter int unsigned         LEN_BIT     = FETCH_LEN_BIT,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    localparam int unsigned MB_LOG = $clog2(MEM_BYTES),
    localparam int unsigned AW     = PC_WIDTH - MB_LOG
) (
    input  logic                   clk,
    input  logic                   rst_async_n,
    input  logic                   redirect_valid,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic                   inst_valid,
    input  logic                   inst_ready,
    output logic [15:0]            inst,
    output logic                   inst_len2,
    output logic [PC_WIDTH-1:0]    inst_pc,
    output logic                   mem_req,
    output logic [AW-1:0]          mem_addr,
    input  logic [8*MEM_BYTES-1:0] mem_rdata
);

    localparam int unsigned CNT_W = $clog2(QUEUE_BYTES + 1);
    localparam int unsigned OFF_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
    localparam int unsigned UW    = CNT_W + 1;
    localparam int unsigned SW    = OFF_W + 1;

    fetch_state_t          state_q, state_d;
    logic                  is_first;
    logic                  inflight_q, inflight_d;
    logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PC_WIDTH-1:0]   inst_pc_q, inst_pc_d;
    logic                  resp_valid;
    logic [OFF_W-1:0]      resp_off;
    logic [UW-1:0]         used;
    logic [CNT_W-1:0]      q_count;
    logic [15:0]           q_peek;
    logic                  q_wr_en, q_pop;
    logic [OFF_W-1:0]      q_wr_off;
    logic [7:0]            src0, src1;
    logic                  src_ok;
    fetch_len_t            head_len;
    logic                  pop;
`ifdef FETCH_BYPASS_EN
    logic [15:0]           resp_pair;
    logic                  resp_avail2;
    logic                  bypass_hit;
    logic [SW-1:0]         bypass_skip;
`endif

    // ---------------- fetch FSM ----------------
    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            state_q <= FS_FIRST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_valid) begin
            state_d = FS_FIRST;
        end else if (resp_valid) begin
            state_d = FS_STREAM;
        end
    end

    always_comb begin
        is_first = (state_q == FS_FIRST);
    end

    // ---------------- memory issue ----------------
    // A redirect drops the response of the cycle it coincides with.
    assign resp_valid = inflight_q && !redirect_valid;
    assign resp_off   = is_first ? OFF_W'(inst_pc_q & PC_WIDTH'(MEM_BYTES - 1)) : '0;

    // Space already promised to an in-flight word counts as used.
    assign used    = UW'(q_count) + (inflight_q ? UW'(MEM_BYTES) : '0);
    assign mem_req = rst_async_n && !redirect_valid && (used <= UW'(QUEUE_BYTES - MEM_BYTES));
    assign mem_addr = fetch_pc_q[PC_WIDTH-1:MB_LOG];

    always_comb begin
        inflight_d = mem_req;
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
        end else if (mem_req) begin
            fetch_pc_d = (fetch_pc_q & ~PC_WIDTH'(MEM_BYTES - 1)) + PC_WIDTH'(MEM_BYTES);
        end
    end

    // ---------------- decode output ----------------
`ifdef FETCH_BYPASS_EN
    assign resp_pair   = 16'({8'h00, mem_rdata} >> (8 * resp_off));
    assign resp_avail2 = (32'(resp_off) + 32'd1) < MEM_BYTES;
    assign bypass_hit  = resp_valid && (q_count == '0);
`endif

    always_comb begin
        src0   = q_peek[7:0];
        src1   = q_peek[15:8];
        src_ok = (q_count >= CNT_W'(2)) || ((q_count != '0) && !q_peek[LEN_BIT]);
`ifdef FETCH_BYPASS_EN
        if (bypass_hit) begin
            src0   = resp_pair[7:0];
            src1   = resp_pair[15:8];
            src_ok = !resp_pair[LEN_BIT] || resp_avail2;
        end
`endif
        head_len   = src0[LEN_BIT] ? LEN2 : LEN1;
        inst_valid = src_ok;
        inst_len2  = src_ok && (head_len == LEN2);
        inst       = '0;
        if (src_ok) begin
            inst = {(head_len == LEN2) ? src1 : 8'h00, src0};
        end
    end

    assign pop = inst_valid && inst_ready && !redirect_valid;

    always_comb begin
        inst_pc_d = inst_pc_q;
        if (redirect_valid) begin
            inst_pc_d = redirect_pc;
        end else if (pop) begin
            inst_pc_d = inst_pc_q + ((head_len == LEN2) ? PC_WIDTH'(2) : PC_WIDTH'(1));
        end
    end

`ifdef FETCH_BYPASS_EN
    assign bypass_skip = SW'(resp_off) + ((head_len == LEN2) ? SW'(2) : SW'(1));
`endif

    // A bypassed pop consumes bytes straight from mem_rdata, so only the
    // bytes behind it are stored and the queue itself is not popped.
    always_comb begin
        q_wr_en  = resp_valid;
        q_wr_off = resp_off;
        q_pop    = pop;
`ifdef FETCH_BYPASS_EN
        if (bypass_hit && pop) begin
            q_pop = 1'b0;
            if (32'(bypass_skip) >= MEM_BYTES) begin
                q_wr_en = 1'b0;
            end else begin
                q_wr_off = OFF_W'(bypass_skip);
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_async_n) begin
        if (!rst_async_n) begin
            inflight_q <= 1'b0;
            fetch_pc_q <= RESET_PC;
            inst_pc_q  <= RESET_PC;
        end else begin
            inflight_q <= inflight_d;
            fetch_pc_q <= fetch_pc_d;
            inst_pc_q  <= inst_pc_d;
        end
    end

    assign inst_pc = inst_pc_q;

    fetch_byte_queue #(
        .QUEUE_BYTES (QUEUE_BYTES),
        .MEM_BYTES   (MEM_BYTES)
    ) u_queue (
        .clk_i     (clk),
        .rst_ni    (rst_async_n),
        .flush_i   (redirect_valid),
        .wr_en_i   (q_wr_en),
        .wr_off_i  (q_wr_off),
        .wr_data_i (mem_rdata),
        .pop_i     (q_pop),
        .pop_len_i (head_len),
        .peek_o    (q_peek),
        .count_o   (q_count)
    );

endmodule
